// File: rtl/fifo_sync_ctrl_if.sv
// Handshake bundle between a same-clock producer/consumer and fifo_sync_ctrl.
// master drives requests; slave (the FIFO) drives data and status.
interface fifo_sync_ctrl_if #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  logic                  fifo_flush;
  logic                  fifo_wr_en;
  logic [FIFO_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_rd_en;
  logic [FIFO_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_almost_full;
  logic                  fifo_almost_empty;
  logic [ADDR_W:0]       fifo_count;
  logic                  fifo_wr_err;
  logic                  fifo_rd_err;

  modport master (
    output fifo_flush, fifo_wr_en, fifo_wr_data, fifo_rd_en,
    input  fifo_rd_data, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_count, fifo_wr_err, fifo_rd_err
  );

  modport slave (
    input  fifo_flush, fifo_wr_en, fifo_wr_data, fifo_rd_en,
    output fifo_rd_data, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_count, fifo_wr_err, fifo_rd_err
  );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags, synchronous
// flush and one-cycle error pulses for rejected requests.
module fifo_sync_ctrl #(
  parameter int FIFO_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic            clk,
  input  logic            rst,
  fifo_sync_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_ZERO = cnt_t'(0);
  localparam cnt_t DEPTH_C  = cnt_t'(FIFO_DEPTH);
  localparam cnt_t AFULL_C  = cnt_t'(AFULL_THRESH);
  localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_THRESH);

  logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] rd_data_r;
  ptr_t                  wr_ptr_r;
  ptr_t                  rd_ptr_r;
  cnt_t                  count_r;
  cnt_t                  count_next_s;
  logic                  wr_err_r;
  logic                  rd_err_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_accept_s;
  logic                  rd_accept_s;
  logic                  wr_err_s;
  logic                  rd_err_s;

  // Status comes only from the registered count, never from pointer compare.
  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == CNT_ZERO);

  // Request acceptance; a flush suppresses everything in its cycle, errors included.
  always_comb begin
    rd_accept_s  = 1'b0;
    wr_accept_s  = 1'b0;
    rd_err_s     = 1'b0;
    wr_err_s     = 1'b0;
    count_next_s = count_r;
    if (bus.fifo_flush) begin
      count_next_s = CNT_ZERO;
    end else begin
      rd_accept_s = bus.fifo_rd_en & ~empty_s;
      // A read in the same cycle frees a slot, so a full FIFO still takes the write.
      wr_accept_s = bus.fifo_wr_en & (~full_s | rd_accept_s);
      rd_err_s    = bus.fifo_rd_en & empty_s;
      wr_err_s    = bus.fifo_wr_en & ~wr_accept_s;
      case ({wr_accept_s, rd_accept_s})
        2'b10:   count_next_s = count_r + CNT_ONE;
        2'b01:   count_next_s = count_r - CNT_ONE;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Control state: pointers, count, read data and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      rd_data_r <= '0;
      wr_err_r  <= 1'b0;
      rd_err_r  <= 1'b0;
    end else begin
      count_r  <= count_next_s;
      wr_err_r <= wr_err_s;
      rd_err_r <= rd_err_s;
      if (bus.fifo_flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (wr_accept_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (rd_accept_s) begin
          rd_ptr_r  <= rd_ptr_r + PTR_ONE;
          rd_data_r <= mem_r[rd_ptr_r];
        end
      end
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= bus.fifo_wr_data;
    end
  end

  assign bus.fifo_rd_data      = rd_data_r;
  assign bus.fifo_count        = count_r;
  assign bus.fifo_full         = full_s;
  assign bus.fifo_empty        = empty_s;
  assign bus.fifo_almost_full  = (count_r >= AFULL_C);
  assign bus.fifo_almost_empty = (count_r <= AEMPTY_C);
  assign bus.fifo_wr_err       = wr_err_r;
  assign bus.fifo_rd_err       = rd_err_r;
endmodule
